// File: rtl/unpack_pkg.sv
// Shared constants and types for the 32B<->160B packer/unpacker pair.
// WORD_BYTES : bytes per narrow word; PACK_WORDS : words per wide beat.
// beat_t     : payload of one wide output beat (framing, byte count, data).
package unpack_pkg;

  localparam int unsigned WORD_BYTES = 32;
  localparam int unsigned PACK_WORDS = 5;
  localparam int unsigned BEAT_BYTES = WORD_BYTES * PACK_WORDS;
  localparam int unsigned VBC_W      = 8;
  localparam int unsigned WORD_W     = WORD_BYTES * 8;
  localparam int unsigned BEAT_W     = BEAT_BYTES * 8;
  // The last word of a beat never enters the accumulator, so it holds one less.
  localparam int unsigned ACC_WORDS  = PACK_WORDS - 1;
  localparam int unsigned ACC_W      = ACC_WORDS * WORD_W;
  localparam int unsigned CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DROP  = 2'd2
  } packer_state_e;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [VBC_W-1:0]  vbc;
    logic [BEAT_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/packer_accum.sv
// Word accumulator for packer_fsm: a left-shifting register of ACC_WORDS
// slices plus an occupancy count.
// Ports:
//   clk, reset_L : clock, async active-low reset
//   shift        : push word into slice 0, older words move up one slice
//   clear        : empty the accumulator (applied before a same-cycle shift)
//   word         : incoming 256b word
//   slices       : accumulator contents, slice 0 in the low bits
//   cnt          : number of occupied slices, 0..ACC_WORDS
module packer_accum
  import unpack_pkg::*;
(
  input  logic              clk,
  input  logic              reset_L,
  input  logic              shift,
  input  logic              clear,
  input  logic [WORD_W-1:0] word,
  output logic [ACC_W-1:0]  slices,
  output logic [CNT_W-1:0]  cnt
);

  logic [ACC_W-1:0] base_slices;
  logic [CNT_W-1:0] base_cnt;
  logic [ACC_W-1:0] slices_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Clear first so that clear+shift starts a fresh beat with this word.
  always_comb begin
    base_slices = clear ? '0 : slices;
    base_cnt    = clear ? '0 : cnt;
    slices_nxt  = base_slices;
    cnt_nxt     = base_cnt;
    if (shift) begin
      slices_nxt = {base_slices[ACC_W-WORD_W-1:0], word};
      cnt_nxt    = base_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      slices <= '0;
      cnt    <= '0;
    end else begin
      slices <= slices_nxt;
      cnt    <= cnt_nxt;
    end
  end

endmodule

// File: rtl/packer_fsm.sv
// Packs a stream of 32-byte words into 160-byte beats, keeping sop/eop
// framing and byte counts. First word of a beat lands in the highest
// occupied slice, last word in slice 0 (right-aligned).
// Optional build macro PACKER_ERR_CHK_EN adds protocol checking: an err
// pulse output and a DROP state that discards the rest of a bad packet.
// Ports:
//   clk, reset_L        : clock, async active-low reset
//   val/sop/eop/vbc/data: input word and framing; taken when val && ready
//   ready               : input can be accepted (no pending beat, or it drains)
//   o_rdy               : downstream accepts the beat
//   o_val/o_sop/o_eop/o_vbc/o_data : registered output beat
//   idle                : no packet in progress and no beat pending
//   err                 : (PACKER_ERR_CHK_EN only) one-cycle violation pulse
module packer_fsm
  import unpack_pkg::*;
(
  input  logic              clk,
  input  logic              reset_L,
  input  logic              val,
  input  logic              sop,
  input  logic              eop,
  input  logic [VBC_W-1:0]  vbc,
  input  logic [WORD_W-1:0] data,
  output logic              ready,
  input  logic              o_rdy,
  output logic              o_val,
  output logic              o_sop,
  output logic              o_eop,
  output logic [VBC_W-1:0]  o_vbc,
  output logic [BEAT_W-1:0] o_data,
  output logic              idle
`ifdef PACKER_ERR_CHK_EN
  ,
  output logic              err
`endif
);

  packer_state_e    state, state_nxt;
  logic             first_sop_q, first_sop_nxt;
  logic             accept;
  logic             shift, clear;
  logic [ACC_W-1:0] slices;
  logic [CNT_W-1:0] cnt;
  logic             take_word, new_pkt, flush;
  logic [ACC_W-1:0] use_slices;
  logic [CNT_W-1:0] use_cnt;
  logic             sop_first;
  logic [VBC_W-1:0] word_bytes;
  beat_t            beat_d, beat_q;
  logic             o_val_q;
`ifdef PACKER_ERR_CHK_EN
  logic             viol;
  logic             err_nxt;
  logic             err_q;
`endif

  assign ready  = !o_val_q || o_rdy;
  assign accept = val && ready;
  assign idle   = (state == IDLE) && !o_val_q;

  assign o_val  = o_val_q;
  assign o_sop  = beat_q.sop;
  assign o_eop  = beat_q.eop;
  assign o_vbc  = beat_q.vbc;
  assign o_data = beat_q.data;
`ifdef PACKER_ERR_CHK_EN
  assign err    = err_q;
`endif

  packer_accum u_accum (
    .clk     (clk),
    .reset_L (reset_L),
    .shift   (shift),
    .clear   (clear),
    .word    (data),
    .slices  (slices),
    .cnt     (cnt)
  );

  // Next-state, accumulator control and beat assembly.
  always_comb begin
    state_nxt     = state;
    first_sop_nxt = first_sop_q;
    shift         = 1'b0;
    clear         = 1'b0;
    flush         = 1'b0;
    take_word     = 1'b0;
    new_pkt       = 1'b0;
    beat_d        = '0;
    use_slices    = slices;
    use_cnt       = cnt;
    sop_first     = first_sop_q;
    // Only the packet's last word may be short; others always count as full.
    word_bytes    = eop ? vbc : VBC_W'(WORD_BYTES);
`ifdef PACKER_ERR_CHK_EN
    viol          = 1'b0;
    err_nxt       = 1'b0;
`endif

    if (accept) begin
`ifdef PACKER_ERR_CHK_EN
      viol = (state != DROP) &&
             (((state == IDLE) && !sop) ||
              ((state == ACCUM) && sop) ||
              (!eop && (vbc != VBC_W'(WORD_BYTES))) ||
              (vbc > VBC_W'(WORD_BYTES)));
      if (state == DROP) begin
        if (eop) state_nxt = IDLE;
      end else if (viol) begin
        err_nxt = 1'b1;
        if (state == ACCUM) begin
          clear         = 1'b1;
          first_sop_nxt = 1'b0;
          // An offending eop word already closes the packet.
          state_nxt     = eop ? IDLE : DROP;
        end
      end else begin
        take_word = (vbc != '0);
        new_pkt   = (state == IDLE);
      end
`else
      // Stray non-sop words in IDLE are dropped; sop in ACCUM restarts.
      take_word = (vbc != '0) && (sop || (state == ACCUM));
      new_pkt   = sop;
`endif
    end

    if (take_word) begin
      if (new_pkt) begin
        use_slices = '0;
        use_cnt    = '0;
        sop_first  = 1'b1;
      end
      if (eop || (use_cnt == CNT_W'(ACC_WORDS))) begin
        flush         = 1'b1;
        clear         = 1'b1;
        beat_d.sop    = sop_first;
        beat_d.eop    = eop;
        beat_d.vbc    = VBC_W'(WORD_BYTES * use_cnt) + word_bytes;
        beat_d.data   = {use_slices, data};
        first_sop_nxt = 1'b0;
        state_nxt     = eop ? IDLE : ACCUM;
      end else begin
        shift         = 1'b1;
        clear         = new_pkt;
        first_sop_nxt = sop_first;
        state_nxt     = ACCUM;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state       <= IDLE;
      first_sop_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      first_sop_q <= first_sop_nxt;
    end
  end

  // Output beat register; a flush may replace a beat being taken this cycle.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      o_val_q <= 1'b0;
      beat_q  <= '0;
    end else if (flush) begin
      o_val_q <= 1'b1;
      beat_q  <= beat_d;
    end else if (o_rdy) begin
      o_val_q <= 1'b0;
    end
  end

`ifdef PACKER_ERR_CHK_EN
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) err_q <= 1'b0;
    else          err_q <= err_nxt;
  end
`endif

endmodule

// File: doc/packer_fsm.md
Name: packer_fsm

Overview:
- Inverse of the 160B-to-32B unpacker. Accepts a packet stream of 32-byte words and packs up to 5 consecutive words into one 160-byte output beat.
- Sits upstream of the unpacker in loopback/verif setups, and on the transmit side of the datapath.
- Keeps per-packet sop/eop framing and byte counts.
- Provides input backpressure (ready) and honours downstream backpressure (o_rdy).

Parameters:
- WORD_BYTES, 32, bytes per input word.
- PACK_WORDS, 5, input words per output beat.
- BEAT_BYTES, WORD_BYTES*PACK_WORDS (160), derived; not to be overridden.

Ports:
- clk  input  1  clock.
- reset_L  input  1  reset. Asynchronous assert, active-low.
- val  input  1  input word valid.
- sop  input  1  first word of packet.
- eop  input  1  last word of packet.
- vbc  input  8  valid bytes in the input word, 0..32.
- data  input  256  input word.
- ready  output  1  input accepted when val && ready.
- o_rdy  input  1  downstream can take the output beat.
- o_val  output  1  output beat valid.
- o_sop  output  1  output beat holds the packet start.
- o_eop  output  1  output beat holds the packet end.
- o_vbc  output  8  valid bytes in the beat, 1..160.
- o_data  output  1280  packed beat.
- idle  output  1  no packet in progress and no beat pending.

Behaviour:
- Reset values: all outputs 0, except ready=1 and idle=1. Accumulator, word count and state are cleared. Reset mid-packet discards partial data, with no output.
- Handshake: accept = val && ready.
- ready = !o_val || o_rdy. Input stalls only while a beat is pending and not being taken.
- The output beat is held stable until o_val && o_rdy.
- Accumulator: shift register of 4 x 256b plus count cnt (0..4).
  - Each accepted non-flushing word shifts left 256 and loads into slice 0.
  - Result: the first word of a beat lands in the highest occupied slice, and the last word lands in slice 0. Data is right-aligned, matching the unpacker's extraction order.
- Flush condition: accepted word has eop, or cnt==4 (this is the 5th word).
- On flush, the next cycle has:
  - o_val=1.
  - o_data = {zeros, accumulator, data}.
  - o_vbc = 32*cnt + vbc.
  - o_sop = the sop of the beat's first word.
  - o_eop = eop of the flushing word.
  - cnt is cleared in the same cycle.
- Latency is 1 cycle from the flushing accept to o_val.
- Word validity rules:
  - Non-eop words are counted as 32 bytes.
  - eop word vbc is 1..32, copied verbatim.
  - An accepted word with vbc==0 is consumed and dropped, with no state change. It never produces a beat.
- States:
  - IDLE: waiting for sop. Accepted sop with vbc>0 goes to ACCUM, or flushes directly if eop is also set.
  - ACCUM: in packet.
    - A flush with eop goes back to IDLE.
    - A flush without eop stays in ACCUM, and the next beat has o_sop=0.
- Packets longer than 160B produce several beats: first beat o_sop=1, o_vbc=160; the final beat carries o_eop.
- Simultaneous events:
  - A flush while the previous beat is being taken (o_val && o_rdy) loads the new beat with no bubble.
  - ready stays 1 throughout.
- idle = (state==IDLE) && !o_val.
- Protocol without the checker:
  - A non-sop word in IDLE is dropped.
  - sop in ACCUM restarts the accumulator: prior partial data is discarded and there is no output.

Optional Feature:
- PACKER_ERR_CHK_EN defined: adds output err (1 bit, reset 0) and state DROP.
  - err pulses for 1 cycle on these violations: non-sop word in IDLE; sop in ACCUM; non-eop word with vbc!=32; vbc>32.
  - On a violation in ACCUM, partial data is discarded and the FSM enters DROP.
  - DROP consumes words (ready per normal rule) without output until an accepted eop, then returns to IDLE.
  - In IDLE, the offending word is dropped and the FSM stays in IDLE.
- Undefined: no err port, no DROP state. Behaviour is as in the protocol rules above.

Decomposition:
- Shared package unpack_pkg, also usable by the unpacker:
  - WORD_BYTES=32, PACK_WORDS=5, BEAT_BYTES=160.
  - VBC_W=8.
  - typedef enum packer_state_e {IDLE, ACCUM, DROP}.
- One sub-module, packer_accum: shift register plus cnt, with ports shift/clear/word in, slices/cnt out.
- The FSM, handshake and output register stay in packer_fsm.

Test Plan:
- Single word: sop+eop, vbc=10, data=A, o_rdy=1.
  - Next cycle: o_val=1, o_sop=1, o_eop=1, o_vbc=10, o_data[255:0]=A, upper bits 0.
- 3-word packet W0,W1,W2 with last vbc=5.
  - One beat: o_vbc=69, o_data[767:512]=W0, [511:256]=W1, [255:0]=W2, sop=eop=1.
- 7-word packet with last vbc=32.
  - Beat 1: vbc=160, sop=1, eop=0, W0 in [1279:1024].
  - Beat 2: vbc=64, sop=0, eop=1.
- Backpressure: o_rdy=0 while a beat is pending.
  - ready=0, beat held stable for 3 cycles.
  - o_rdy=1 releases it, and a back-to-back flush loads the next beat with no gap.
- Reset asserted after 2 words of a packet: outputs 0 immediately, idle=1, and no beat emitted after release.
- With PACKER_ERR_CHK_EN: sop received in ACCUM.
  - err=1 for 1 cycle, no beat.
  - Words dropped until eop; the next sop packet packs correctly.
